// File: rtl/param_ring_counter.sv
// rtl/param_ring_counter.sv - parametrised ring/Johnson counter with wrap pulse
// Optional illegal-state recovery: define RING_CTR_SELF_CORRECT_EN.
module param_ring_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err
);

    localparam logic [1:0] MODE_RING    = 2'b00;
    localparam logic [1:0] MODE_JOHNSON = 2'b01;

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] ref_val;
    logic             stepping;
    logic             illegal;

    always_comb begin
        if (mode == MODE_JOHNSON)
            step_val = dir ? {~out_q[0], out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
        else
            step_val = dir ? {out_q[0], out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], out_q[WIDTH-1]};
    end

    // Wrap reference, also the recovery target when self-correction is built
    assign ref_val  = (mode == MODE_JOHNSON) ? '0 : SEED;
    assign stepping = en && ((mode == MODE_RING) || (mode == MODE_JOHNSON));

`ifdef RING_CTR_SELF_CORRECT_EN
    function automatic logic [5:0] ones(input logic [WIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++)
            n = n + 6'(v[i]);
        return n;
    endfunction

    logic [WIDTH-2:0] edges;
    assign edges   = out_q[WIDTH-2:0] ^ out_q[WIDTH-1:1];
    assign illegal = (mode == MODE_JOHNSON) ? (ones({1'b0, edges}) > 6'd1)
                                            : (ones(out_q) != 6'd1);
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (stepping) begin
            if (illegal) begin
                out_d = ref_val;
                err_d = 1'b1;
            end else begin
                out_d  = step_val;
                wrap_d = (step_val == ref_val);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= SEED;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_param_ring_counter.sv
// tb/tb_param_ring_counter.sv - directed vector bench for param_ring_counter
module tb_param_ring_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, dir, load;
    logic [1:0] mode;
    logic [3:0] load_val, out;
    logic       wrap, err;

    logic       rst8, en8, dir8, load8;
    logic [1:0] mode8;
    logic [7:0] load_val8, out8;
    logic       wrap8, err8;

    param_ring_counter #(.WIDTH(4), .SEED(4'b0001)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .out(out), .wrap(wrap), .err(err)
    );

    param_ring_counter #(.WIDTH(8), .SEED(8'b0000_0100)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .dir(dir8), .load(load8),
        .load_val(load_val8), .out(out8), .wrap(wrap8), .err(err8)
    );

    typedef struct {
        logic       rst, load, en;
        logic [1:0] mode;
        logic       dir;
        logic [3:0] lv;
        logic [3:0] eo;
        logic       ew, ee;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic l, input logic e, input logic [1:0] m,
                       input logic d, input logic [3:0] lv, input logic [3:0] eo,
                       input logic ew, input logic ee);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.mode = m; v.dir = d;
        v.lv = lv; v.eo = eo; v.ew = ew; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        // rst load en mode dir lv | out wrap err
        add(1, 0, 0, 2'b00, 0, 4'h0, 4'b0001, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0100, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b1000, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 1, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0100, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b1000, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 1, 0);
        add(0, 0, 0, 2'b00, 0, 4'h0, 4'b0001, 0, 0);
        // Johnson, both directions
        add(0, 1, 0, 2'b01, 0, 4'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b0001, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b0011, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b0111, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b1111, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b1110, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b1100, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b1000, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b0000, 1, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b1000, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b1100, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b1110, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b1111, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b0111, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b0011, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b0001, 0, 0);
        add(0, 0, 1, 2'b01, 1, 4'h0, 4'b0000, 1, 0);
        // Priority: load over en, rst over load
        add(0, 1, 0, 2'b00, 0, 4'b0100, 4'b0100, 0, 0);
        add(0, 1, 1, 2'b00, 0, 4'b1000, 4'b1000, 0, 0);
        add(1, 1, 1, 2'b00, 0, 4'b1000, 4'b0001, 0, 0);
        // Hold / reserved freeze, then direction toggles
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b10, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b10, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b11, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0100, 0, 0);
        add(0, 0, 1, 2'b00, 1, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b00, 1, 4'h0, 4'b0001, 1, 0);
        add(0, 0, 1, 2'b00, 1, 4'h0, 4'b1000, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 1, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0100, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b1000, 0, 0);
        // Mode switch: wrap follows the Johnson reference (all zeros)
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b0000, 1, 0);
        // Mid-sequence reset
        add(0, 1, 0, 2'b00, 0, 4'b0100, 4'b0100, 0, 0);
        add(1, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 0, 0);
        // Illegal states; hold mode never checks
        add(0, 1, 0, 2'b10, 0, 4'b0110, 4'b0110, 0, 0);
        add(0, 0, 1, 2'b10, 0, 4'h0, 4'b0110, 0, 0);
`ifdef RING_CTR_SELF_CORRECT_EN
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 0, 1);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 1, 0, 2'b01, 0, 4'b0101, 4'b0101, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b0000, 0, 1);
        add(0, 1, 0, 2'b00, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 0, 1);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0010, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0100, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b1000, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0001, 1, 0);
`else
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b1100, 0, 0);
        add(0, 0, 1, 2'b00, 0, 4'h0, 4'b1001, 0, 0);
        add(0, 1, 0, 2'b01, 0, 4'b0101, 4'b0101, 0, 0);
        add(0, 0, 1, 2'b01, 0, 4'h0, 4'b1011, 0, 0);
        add(0, 1, 0, 2'b00, 0, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 2'b00, 0, 4'h0, 4'b0000, 0, 0);
`endif

        rst = 1'b1; load = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; load_val = '0;
        rst8 = 1'b1; load8 = 1'b0; en8 = 1'b0; mode8 = 2'b00; dir8 = 1'b0; load_val8 = '0;
        #2;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en;
            mode = vecs[i].mode; dir = vecs[i].dir; load_val = vecs[i].lv;
            tick();
            check($sformatf("v%0d_out", i),  32'(out),  32'(vecs[i].eo));
            check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].ew));
            check($sformatf("v%0d_err", i),  32'(err),  32'(vecs[i].ee));
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;

        // WIDTH=8, non-default seed: reset value and periods
        tick();
        check("w8_reset_out", 32'(out8), 32'h04);
        check("w8_reset_wrap", 32'(wrap8), 32'h0);
        rst8 = 1'b0; en8 = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (!wrap8 && cnt < 40);
        check("w8_ring_period", 32'(cnt), 32'd8);
        check("w8_ring_wrap_out", 32'(out8), 32'h04);

        en8 = 1'b0; load8 = 1'b1; load_val8 = 8'h00; mode8 = 2'b01;
        tick();
        check("w8_load_wrap", 32'(wrap8), 32'h0);
        load8 = 1'b0; en8 = 1'b1;
        tick();
        check("w8_john_first", 32'(out8), 32'h01);
        cnt = 1;
        while (!wrap8 && cnt < 40) begin tick(); cnt++; end
        check("w8_john_period", 32'(cnt), 32'd16);
        check("w8_john_wrap_out", 32'(out8), 32'h00);

        dir8 = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (!wrap8 && cnt < 40);
        check("w8_john_rev_period", 32'(cnt), 32'd16);
        check("w8_err", 32'(err8), 32'h0);
        en8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
